// File: rtl/ccd_frame_sequencer.sv
// ccd_frame_sequencer
// -------------------
// Sequences one linear-CCD acquisition: debounces the capture button,
// requests a frame from the CCD driver, waits for the driver to finish
// writing line RAM, then reads the RAM back one pixel at a time into a
// valid/ready byte stream.
//
// Optional feature: define FRAME_HEADER_EN to prefix every frame with the
// two header bytes 0xA5, 0x5A (SOF moves to 0xA5). Undefined by default.
//
// Ports:
//   clk, rst_n       system clock, synchronous active-low reset
//   button           capture button, active-low, already synchronised
//   continuous       1: re-arm straight after a frame's last byte
//   shoot            frame request to the CCD driver
//   frameDone        one-cycle pulse from the driver: frame stored
//   pxcount          driver pixel counter, 0 when the driver is idle
//   rdaddress, rden  RAM read port (q valid one cycle after rden)
//   q                RAM read data
//   out_data, out_valid, out_ready, out_sof, out_eof
//                    host byte stream
//   busy             high in every state except IDLE
//   frames_sent      completed-frame counter (wraps)
//   dbg_state        current FSM state, for observation only
//
// Stream handshake: a byte transfers on every rising edge where
// out_valid && out_ready. Once out_valid rises, out_valid, out_data,
// out_sof and out_eof hold until that transfer happens; out_valid never
// depends combinationally on out_ready.

module ccd_frame_sequencer #(
    parameter int PIXELS   = 5475,
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8,
    parameter int DEBOUNCE = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              button,
    input  logic              continuous,
    output logic              shoot,
    input  logic              frameDone,
    input  logic [12:0]       pxcount,
    output logic [ADDR_W-1:0] rdaddress,
    output logic              rden,
    input  logic [DATA_W-1:0] q,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sof,
    output logic              out_eof,
    output logic              busy,
    output logic [15:0]       frames_sent,
    output logic [2:0]        dbg_state
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SHOOT   = 3'd1;
    localparam logic [2:0] S_SETTLE  = 3'd2;
    localparam logic [2:0] S_RD_REQ  = 3'd3;
    localparam logic [2:0] S_RD_WAIT = 3'd4;
    localparam logic [2:0] S_PRESENT = 3'd5;
`ifdef FRAME_HEADER_EN
    localparam logic [2:0] S_HDR0    = 3'd6;
    localparam logic [2:0] S_HDR1    = 3'd7;
    localparam logic [DATA_W-1:0] HDR0_BYTE = DATA_W'(8'hA5);
    localparam logic [DATA_W-1:0] HDR1_BYTE = DATA_W'(8'h5A);
`endif

    localparam int CNT_W = $clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0]  DEB_MAX   = CNT_W'(DEBOUNCE);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);

    logic [2:0]       state;
    logic [CNT_W-1:0] deb_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            deb_cnt     <= '0;
            rdaddress   <= '0;
            out_data    <= '0;
            frames_sent <= '0;
        end else begin
            // Button history only matters while idle; elsewhere it is discarded.
            if (state != S_IDLE) begin
                deb_cnt <= '0;
            end

            case (state)
                S_IDLE: begin
                    if (button) begin
                        // Release: only counts after a full stable press.
                        deb_cnt <= '0;
                        if (deb_cnt == DEB_MAX) begin
                            state <= S_SHOOT;
                        end
                    end else if (deb_cnt != DEB_MAX) begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end

                S_SHOOT: begin
                    if (frameDone) begin
                        state <= S_SETTLE;
                    end
                end

                S_SETTLE: begin
                    rdaddress <= '0;
                    // Driver may still be finishing its last writes; wait for idle.
                    if (pxcount == 13'd0) begin
`ifdef FRAME_HEADER_EN
                        state    <= S_HDR0;
                        out_data <= HDR0_BYTE;
`else
                        state    <= S_RD_REQ;
`endif
                    end
                end

`ifdef FRAME_HEADER_EN
                S_HDR0: begin
                    if (out_ready) begin
                        state    <= S_HDR1;
                        out_data <= HDR1_BYTE;
                    end
                end

                S_HDR1: begin
                    if (out_ready) begin
                        state <= S_RD_REQ;
                    end
                end
`endif

                S_RD_REQ: begin
                    state <= S_RD_WAIT;
                end

                S_RD_WAIT: begin
                    // RAM data is valid exactly one cycle after rden.
                    out_data <= q;
                    state    <= S_PRESENT;
                end

                S_PRESENT: begin
                    if (out_ready) begin
                        if (rdaddress == LAST_ADDR) begin
                            rdaddress   <= '0;
                            frames_sent <= frames_sent + 16'd1;
                            state       <= continuous ? S_SHOOT : S_IDLE;
                        end else begin
                            rdaddress <= rdaddress + 1'b1;
                            state     <= S_RD_REQ;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // All control outputs are decoded from the registered state, so reset
    // clears them on the same edge that clears the state.
    assign shoot     = (state == S_SHOOT);
    assign rden      = (state == S_RD_REQ);
    assign busy      = (state != S_IDLE);
    assign out_eof   = (state == S_PRESENT) && (rdaddress == LAST_ADDR);
    assign dbg_state = state;

`ifdef FRAME_HEADER_EN
    assign out_valid = (state == S_PRESENT) || (state == S_HDR0) || (state == S_HDR1);
    assign out_sof   = (state == S_HDR0);
`else
    assign out_valid = (state == S_PRESENT);
    assign out_sof   = (state == S_PRESENT) && (rdaddress == '0);
`endif

endmodule
